// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with hold-while-requesting ownership,
// forced revocation after MAX_HOLD cycles, and fully registered outputs.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [2:0]    owner, owner_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic [7:0]    gnt_nxt;
  logic [2:0]    gnt_id_nxt;
  logic          gnt_valid_nxt;
  logic          timeout_nxt;

  logic          found;
  logic [2:0]    sel;
  logic [2:0]    idx;

  // Rotated priority search: first set request at ptr, ptr+1, ... ptr+7.
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end else begin
        found = found;
        sel   = sel;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    hold_cnt_nxt  = hold_cnt;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (en && found) begin
          state_nxt     = GRANT;
          owner_nxt     = sel;
          gnt_nxt       = 8'd1 << sel;
          gnt_id_nxt    = sel;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = CW'(1);
        end else begin
          gnt_nxt       = 8'd0;
          gnt_id_nxt    = 3'd0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
        end
      end
      GRANT: begin
        // Release is checked first so a same-cycle drop never reports a timeout.
        if (!req[owner]) begin
          state_nxt     = IDLE;
          ptr_nxt       = owner + 3'd1;
          gnt_nxt       = 8'd0;
          gnt_id_nxt    = 3'd0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
        end else if (hold_cnt == CW'(MAX_HOLD)) begin
          state_nxt     = IDLE;
          ptr_nxt       = owner + 3'd1;
          gnt_nxt       = 8'd0;
          gnt_id_nxt    = 3'd0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
          timeout_nxt   = 1'b1;
        end else begin
          hold_cnt_nxt  = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = 8'd0;
        gnt_id_nxt    = 3'd0;
        gnt_valid_nxt = 1'b0;
        hold_cnt_nxt  = '0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      owner     <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed, table-driven bench for rr_arbiter8 with MAX_HOLD=4 plus
// hand-written sequences for rotation through expiry and en gating.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_vec;
  int n_fail;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       timeout;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [7:0] q,
                     input logic [7:0] g, input logic [2:0] id,
                     input logic v, input logic t);
    vec_t x;
    x.rst_n = r; x.en = e; x.req = q;
    x.gnt = g; x.id = id; x.valid = v; x.timeout = t;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [7:0] eg,
                       input logic [2:0] eid, input logic ev, input logic et);
    n_vec++;
    if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || timeout !== et) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
               name, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, et);
    end
  endtask

  // Drive inputs, take one clock edge, then sample outputs 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [7:0] q);
    rst_n = r; en = e; req = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    req    = 8'h00;

    // rst en req -> gnt id valid timeout
    add(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    // short ownership by 4, voluntary release, search resumes at 5
    add(1'b1, 1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    // id 3 owns; other requests must not preempt; then ptr=4 picks 6
    add(1'b1, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h4A, 8'h08, 3'd3, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h4A, 8'h08, 3'd3, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h42, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h42, 8'h40, 3'd6, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    // ptr=7 wraps to 1; release on the very cycle hold reaches 4
    add(1'b1, 1'b1, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    // en low blocks grants; en high grants id ptr=2; reset mid-grant
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'hFF, 8'h04, 3'd2, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'hFF, 8'h04, 3'd2, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      step(vecs[k].rst_n, vecs[k].en, vecs[k].req);
      check($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].id, vecs[k].valid, vecs[k].timeout);
    end

    // Rotation through expiry from ptr=0 with req=1000_0101 held
    begin
      logic [2:0] order [4];
      logic [7:0] one_hot;
      order[0] = 3'd0; order[1] = 3'd2; order[2] = 3'd7; order[3] = 3'd0;
      for (int g = 0; g < 4; g++) begin
        one_hot = 8'd1 << order[g];
        for (int c = 0; c < 4; c++) begin
          step(1'b1, 1'b1, 8'h85);
          check($sformatf("rot%0d_hold%0d", g, c), one_hot, order[g], 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 8'h85);
        check($sformatf("rot%0d_expire", g), 8'h00, 3'd0, 1'b0, 1'b1);
      end
    end

    // ptr=1: grant 2, then en low must not revoke; expiry still fires once
    step(1'b1, 1'b1, 8'h04);
    check("en_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 8'h04);
      check($sformatf("en_low_hold%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 8'h04);
    check("en_low_expire", 8'h00, 3'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h04);
    check("en_low_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h04);
    check("en_regrant", 8'h04, 3'd2, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
